// File: rtl/bist_signature_analyzer.sv
// ----------------------------------------------------------------------------
// bist_signature_analyzer
// Output response analyzer for the BIST path. Compresses circuit-under-test
// response words into a multiple-input signature register (MISR) that uses
// the same tap polynomial as the pattern generator (taps WIDTH-1, WIDTH-4).
// After PATTERN_COUNT accepted words the signature is compared with
// GOLDEN_SIG and a sticky pass/fail result is reported.
//
// Optional feature: define MISR_SIG_OUT_EN to add the `signature` output,
// which exposes the live MISR contents for diagnosis and golden-value
// extraction. All other behaviour is the same with or without it.
// ----------------------------------------------------------------------------
module bist_signature_analyzer #(
    parameter int              WIDTH         = 9,
    parameter int              PATTERN_COUNT = 511,
    parameter logic [WIDTH-1:0] SEED         = '0,
    parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [WIDTH-1:0] pattern_cnt
`ifdef MISR_SIG_OUT_EN
    ,
    output logic [WIDTH-1:0] signature
`endif
);

    // State encoding
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMPRESS = 2'd1;
    localparam logic [1:0] S_COMPARE  = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    // Count value at which the next accepted word is the final one.
    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PATTERN_COUNT - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_misr;
    logic [WIDTH-1:0] r_cnt;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;

    logic [WIDTH-1:0] w_misr_nxt;
    logic             w_accept;
    logic             w_start_ok;

    // Next MISR value: shift left with tap feedback into bit 0, XOR the input.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_misr_nxt    = '0;
        w_misr_nxt    = {r_misr[WIDTH-2:0], r_misr[WIDTH-1] ^ r_misr[WIDTH-4]} ^ data_in;
    end

    // A word is compressed only in COMPRESS; start is honoured only when idle or done.
    assign w_accept   = (r_state == S_COMPRESS) && data_valid;
    assign w_start_ok = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

    // Control state machine, MISR, pattern counter and sticky result registers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_state <= S_IDLE;
            r_misr  <= SEED;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Start loads the seed only; a coincident valid word is dropped.
                    if (w_start_ok) begin
                        r_state <= S_COMPRESS;
                        r_misr  <= SEED;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                end
                S_COMPRESS: begin
                    if (w_accept) begin
                        r_misr <= w_misr_nxt;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    // MISR is frozen here; latch the verdict and finish.
                    r_pass  <= (r_misr == GOLDEN_SIG);
                    r_fail  <= (r_misr != GOLDEN_SIG);
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == S_COMPRESS) || (r_state == S_COMPARE);
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign pattern_cnt = r_cnt;
`ifdef MISR_SIG_OUT_EN
    assign signature   = r_misr;
`endif

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// ----------------------------------------------------------------------------
// tb_bist_signature_analyzer
// Directed self-checking bench. Four analyzer instances with different
// PATTERN_COUNT / SEED / GOLDEN_SIG share one stimulus bus; each directed
// sequence checks the instance it targets against hand-computed results.
// When MISR_SIG_OUT_EN is defined the signature outputs are checked too.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bist_signature_analyzer;

    localparam int W = 9;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] data_in;
    logic         data_valid;

    logic         busy0, done0, pass0, fail0;
    logic         busy1, done1, pass1, fail1;
    logic         busy2, done2, pass2, fail2;
    logic         busy3, done3, pass3, fail3;
    logic [W-1:0] cnt0, cnt1, cnt2, cnt3;
    logic [W-1:0] sig0, sig1, sig2, sig3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    // u0: one word, golden 0A5
    bist_signature_analyzer #(.WIDTH(W), .PATTERN_COUNT(1), .SEED(9'h000), .GOLDEN_SIG(9'h0A5)) u0 (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
        .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .pattern_cnt(cnt0)
`ifdef MISR_SIG_OUT_EN
        , .signature(sig0)
`endif
    );
    // u1: one word, seed 100 exercises tap feedback
    bist_signature_analyzer #(.WIDTH(W), .PATTERN_COUNT(1), .SEED(9'h100), .GOLDEN_SIG(9'h001)) u1 (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
        .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .pattern_cnt(cnt1)
`ifdef MISR_SIG_OUT_EN
        , .signature(sig1)
`endif
    );
    // u2: two words, golden 003
    bist_signature_analyzer #(.WIDTH(W), .PATTERN_COUNT(2), .SEED(9'h000), .GOLDEN_SIG(9'h003)) u2 (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .pattern_cnt(cnt2)
`ifdef MISR_SIG_OUT_EN
        , .signature(sig2)
`endif
    );
    // u3: two words, golden 002 (pins down the 001,000 signature)
    bist_signature_analyzer #(.WIDTH(W), .PATTERN_COUNT(2), .SEED(9'h000), .GOLDEN_SIG(9'h002)) u3 (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
        .busy(busy3), .done(done3), .pass(pass3), .fail(fail3), .pattern_cnt(cnt3)
`ifdef MISR_SIG_OUT_EN
        , .signature(sig3)
`endif
    );

`ifndef MISR_SIG_OUT_EN
    assign sig0 = '0;
    assign sig1 = '0;
    assign sig2 = '0;
    assign sig3 = '0;
`endif

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        data_in    = d;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        data_in    = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data_in = '0; data_valid = 1'b0;
        step(2);
        // Reset state
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_pass_fail", {pass2, fail2}, 2'b00);
        check("rst_cnt", cnt2, 0);
        reset = 1'b0;
        step();
        // Valid words while idle are ignored
        send(9'h0FF);
        check("idle_valid_cnt", cnt2, 0);
        check("idle_busy", busy2, 0);

        // A: single word 0A5, seed 0
        pulse_start();
        check("a_busy", busy0, 1);
        check("a_cnt0", cnt0, 0);
        send(9'h0A5);                     // edge k
        check("a_k_done", done0, 0);
        check("a_k_busy", busy0, 1);
        check("a_k_cnt", cnt0, 1);
        step();                           // edge k+1
        check("a_done", done0, 1);
        check("a_pass_fail", {pass0, fail0}, 2'b10);
        check("a_busy_drop", busy0, 0);
        check("a_u1_fail", {pass1, fail1}, 2'b01);   // 100 -> 0A4 != 001
`ifdef MISR_SIG_OUT_EN
        check("a_sig", sig0, 9'h0A5);
        check("a_u1_sig", sig1, 9'h0A4);
`endif

        // B: seed 100, data 0 -> tap feedback gives 001
        pulse_start();
        check("b_done_clr", done1, 0);
        check("b_pf_clr", {pass1, fail1}, 2'b00);
        send(9'h000);
        step();
        check("b_pass", {pass1, fail1}, 2'b10);
        check("b_u0_fail", {pass0, fail0}, 2'b01);
`ifdef MISR_SIG_OUT_EN
        check("b_sig", sig1, 9'h001);
`endif

        // C: two words 001, 001 with a 3-cycle gap -> 003
        pulse_start();
        send(9'h001);
        step(3);
        check("c_gap_busy", busy2, 1);
        check("c_gap_cnt", cnt2, 1);
        send(9'h001);
        check("c_cnt_k", cnt2, 2);
        check("c_busy_k", busy2, 1);
        step();
        check("c_u2_pass", {done2, pass2, fail2}, 3'b110);
        check("c_u3_fail", {done3, pass3, fail3}, 3'b101);
        check("c_busy_end", busy2, 0);
`ifdef MISR_SIG_OUT_EN
        check("c_sig", sig2, 9'h003);
`endif
        // Valid data in DONE is ignored; results and count hold
        send(9'h1FF);
        step(2);
        check("c_hold_cnt", cnt2, 2);
        check("c_hold_res", {done2, pass2, fail2}, 3'b110);

        // D: start with coincident valid (seed only), then 001, 000 -> 002
        data_in = 9'h001; data_valid = 1'b1;
        pulse_start();
        data_valid = 1'b0;
        check("d_start_cnt", cnt2, 0);
        check("d_done_clr", done2, 0);
        send(9'h001);
        send(9'h000);
        step();
        check("d_u2_fail", {done2, pass2, fail2}, 3'b101);
        check("d_u3_pass", {done3, pass3, fail3}, 3'b110);
        check("d_cnt", cnt3, 2);
`ifdef MISR_SIG_OUT_EN
        check("d_sig", sig2, 9'h002);
`endif

        // E: restart reproduces run C exactly
        pulse_start();
        check("e_clr", {done2, pass2, fail2}, 3'b000);
        send(9'h001);
        send(9'h001);
        step();
        check("e_u2_pass", {done2, pass2, fail2}, 3'b110);

        // F: start ignored during COMPRESS, then reset aborts mid-run
        pulse_start();
        send(9'h001);
        pulse_start();
        check("f_start_ign_cnt", cnt2, 1);
        check("f_start_ign_busy", busy2, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("f_rst_busy", busy2, 0);
        check("f_rst_done", done2, 0);
        check("f_rst_cnt", cnt2, 0);
`ifdef MISR_SIG_OUT_EN
        check("f_rst_sig", sig2, 9'h000);
        check("f_rst_sig1", sig1, 9'h100);
`endif
        step(3);
        check("f_no_done", {done2, pass2, fail2}, 3'b000);
        // Fresh run after reset starts from the seed
        pulse_start();
        send(9'h001);
        send(9'h001);
        step();
        check("f_rerun_pass", {done2, pass2, fail2}, 3'b110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
